// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin index arbiter.
package arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Modulo increment used to rotate the priority pointer past the last served index.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: the first set request at or after ptr, ascending with wrap.
module rr_pick #(
    parameter  int ENCODE_WIDTH = 2,
    localparam int DECODE_WIDTH = 2**ENCODE_WIDTH
) (
    input  logic [DECODE_WIDTH-1:0] req,
    input  logic [ENCODE_WIDTH-1:0] ptr,
    output logic                    any,
    output logic [ENCODE_WIDTH-1:0] idx
);

    logic [DECODE_WIDTH-1:0] rot;
    logic [ENCODE_WIDTH-1:0] off;

    // Rotating right by ptr puts requester ptr at bit 0, so the lowest set bit is the winner offset.
    always_comb begin
        rot = DECODE_WIDTH'({req, req} >> ptr);
        off = '0;
        for (int i = DECODE_WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) off = ENCODE_WIDTH'(i);
        end
    end

    assign any = |req;
    assign idx = off + ptr;

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter issuing a registered grant index for the one-hot decoder stage.
module rr_index_arbiter #(
    parameter  int ENCODE_WIDTH = 2,
    localparam int DECODE_WIDTH = 2**ENCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DECODE_WIDTH-1:0] req,
    input  logic                    grant_ready,
    output logic                    grant_valid,
    output logic [ENCODE_WIDTH-1:0] grant_idx,
    output logic [ENCODE_WIDTH-1:0] ptr
);
    import arb_pkg::*;

    arb_state_t              state;
    logic                    handshake;
    logic [ENCODE_WIDTH-1:0] ptr_next;
    logic [ENCODE_WIDTH-1:0] search_base;
    logic                    pick_any;
    logic [ENCODE_WIDTH-1:0] pick_idx;

    assign handshake = grant_valid & grant_ready;
    assign ptr_next  = ENCODE_WIDTH'(next_ptr(32'(grant_idx), DECODE_WIDTH));

    // On a handshake the search already starts past the served index, giving zero-bubble re-grants.
    assign search_base = (state == GRANT && handshake) ? ptr_next : ptr;

    rr_pick #(.ENCODE_WIDTH(ENCODE_WIDTH)) u_pick (
        .req (req),
        .ptr (search_base),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            ptr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // Grant is held regardless of req until the consumer accepts it.
                    if (handshake) begin
                        ptr <= ptr_next;
                        if (pick_any) begin
                            grant_idx <= pick_idx;
                        end else begin
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed and randomized checks of rr_index_arbiter against a behavioural round-robin model.
module tb_rr_index_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       grant_ready;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [1:0] ptr;
    logic [3:0] dec_out;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_v;
    int m_idx;
    int m_ptr;

    rr_index_arbiter #(.ENCODE_WIDTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant_ready (grant_ready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .ptr         (ptr)
    );

    // Stand-in for the downstream binary-to-one-hot decoder.
    always_comb dec_out = 4'b0001 << grant_idx;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int win(input logic [3:0] r, input int base);
        for (int k = 0; k < 4; k++) begin
            if (r[(base + k) % 4]) return (base + k) % 4;
        end
        return 0;
    endfunction

    // Advance the model by the rules for one edge, clock the DUT, and compare.
    task automatic tick(input string tag);
        if (rst) begin
            m_v = 1'b0; m_idx = 0; m_ptr = 0;
        end else if (!m_v) begin
            if (req != 4'b0) begin
                m_idx = win(req, m_ptr);
                m_v   = 1'b1;
            end
        end else if (grant_ready) begin
            m_ptr = (m_idx + 1) % 4;
            if (req != 4'b0) m_idx = win(req, m_ptr);
            else             m_v = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(grant_valid), 32'(m_v));
        chk({tag, ".idx"},   32'(grant_idx),   32'(m_idx));
        chk({tag, ".ptr"},   32'(ptr),         32'(m_ptr));
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] idx, input logic [1:0] p);
        chk({tag, ".dir_valid"}, 32'(grant_valid), 32'(v));
        chk({tag, ".dir_idx"},   32'(grant_idx),   32'(idx));
        chk({tag, ".dir_ptr"},   32'(ptr),         32'(p));
    endtask

    initial begin
        logic [3:0] onehot [5];
        onehot[0] = 4'b0001; onehot[1] = 4'b0010; onehot[2] = 4'b0100;
        onehot[3] = 4'b1000; onehot[4] = 4'b0001;

        m_v = 1'b0; m_idx = 0; m_ptr = 0;
        rst = 1'b1; req = 4'b1111; grant_ready = 1'b0;

        // Reset held for two edges with all requests high
        tick("rst1"); expect_out("rst1", 1'b0, 2'd0, 2'd0);
        tick("rst2"); expect_out("rst2", 1'b0, 2'd0, 2'd0);

        // Full load with ready: 0,1,2,3,0
        rst = 1'b0; grant_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick("rr");
            expect_out("rr", 1'b1, 2'(i % 4), 2'(i == 0 ? 0 : i % 4));
            chk("rr.dec", 32'(dec_out), 32'(onehot[i]));
        end

        // Drain to IDLE: ptr moves to 1
        req = 4'b0000;
        tick("drain"); expect_out("drain", 1'b0, 2'd0, 2'd1);

        // Single pulse on req[2], grant held while not ready (no retraction)
        req = 4'b0100; grant_ready = 1'b0;
        tick("hold0"); expect_out("hold0", 1'b1, 2'd2, 2'd1);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick("hold"); expect_out("hold", 1'b1, 2'd2, 2'd1);
        end
        grant_ready = 1'b1;
        tick("hold_acc"); expect_out("hold_acc", 1'b0, 2'd2, 2'd3);

        // Wrap-around: ptr=3, req=0011 -> 0 then 1
        req = 4'b0011;
        tick("wrap0"); expect_out("wrap0", 1'b1, 2'd0, 2'd3);
        tick("wrap1"); expect_out("wrap1", 1'b1, 2'd1, 2'd1);
        req = 4'b0000;
        tick("wrap2"); expect_out("wrap2", 1'b0, 2'd1, 2'd2);

        // Reset while a grant is live
        req = 4'b1010;
        tick("pre_rst"); expect_out("pre_rst", 1'b1, 2'd3, 2'd2);
        rst = 1'b1;
        tick("mid_rst"); expect_out("mid_rst", 1'b0, 2'd0, 2'd0);
        rst = 1'b0;
        tick("post_rst"); expect_out("post_rst", 1'b1, 2'd1, 2'd0);

        // Idle for ten cycles: ptr stays put
        req = 4'b0000;
        tick("idle_in"); expect_out("idle_in", 1'b0, 2'd1, 2'd2);
        for (int i = 0; i < 10; i++) tick("idle");
        expect_out("idle_end", 1'b0, 2'd1, 2'd2);

        // Single requester re-granted every cycle
        req = 4'b0010;
        tick("single0"); expect_out("single0", 1'b1, 2'd1, 2'd2);
        for (int i = 0; i < 3; i++) begin
            tick("single"); expect_out("single", 1'b1, 2'd1, 2'd2);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            req         = 4'($urandom_range(0, 15));
            grant_ready = ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 40) == 0);
            tick("rand");
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
